// File: rtl/bitty_sequencer.sv
`default_nettype none
// ==========================================================================
// bitty_sequencer : program memory + issue/wait front end for the bitty core
// Rev 1.0 -- optional watchdog enabled by macro BITTY_SEQ_TIMEOUT_EN
// ==========================================================================
module bitty_sequencer #(
   parameter int DEPTH          = 16,
   parameter int AW             = $clog2(DEPTH),
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [15:0]   load_data,
   input  logic [AW:0]   prog_len,
   input  logic          start,
   input  logic          core_done,
   input  logic [15:0]   core_d_out,
   output logic          run,
   output logic [15:0]   d_instr,
   output logic [AW-1:0] pc,
   output logic [15:0]   last_result,
   output logic          result_valid,
   output logic          busy,
   output logic          finished,
   output logic          error
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   state_t        state;
   logic [15:0]   mem [DEPTH];
   logic [AW:0]   len;
   logic [AW:0]   len_clamped;
   logic [AW-1:0] pc_next;
   logic          last_instr;
   logic          accepting;

   assign len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
   assign pc_next     = pc + AW'(1);
   assign last_instr  = ({1'b0, pc} == (len - (AW+1)'(1)));

`ifdef BITTY_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   assign accepting = (state == S_IDLE) || (state == S_ERROR);
`else
   assign accepting = (state == S_IDLE);
   assign error     = 1'b0;
   if (TIMEOUT_CYCLES < 1) begin : g_no_watchdog
   end
`endif

   // Program memory is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (load_en && accepting) begin
         mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_IDLE;
         pc           <= '0;
         len          <= '0;
         last_result  <= '0;
         run          <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         finished     <= 1'b0;
         d_instr      <= '0;
`ifdef BITTY_SEQ_TIMEOUT_EN
         error        <= 1'b0;
         wd_cnt       <= '0;
`endif
      end else begin
         run          <= 1'b0;
         result_valid <= 1'b0;
         finished     <= 1'b0;
         case (state)
            S_IDLE, S_ERROR: begin
               if (start) begin
`ifdef BITTY_SEQ_TIMEOUT_EN
                  error <= 1'b0;
`endif
                  if (prog_len == '0) begin
                     finished <= 1'b1;
                     state    <= S_IDLE;
                  end else begin
                     len     <= len_clamped;
                     pc      <= '0;
                     d_instr <= mem[0];
                     run     <= 1'b1;
                     busy    <= 1'b1;
                     state   <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
`ifdef BITTY_SEQ_TIMEOUT_EN
               wd_cnt <= '0;
`endif
            end
            S_WAIT: begin
               if (core_done) begin
                  last_result  <= core_d_out;
                  result_valid <= 1'b1;
                  if (last_instr) begin
                     finished <= 1'b1;
                     busy     <= 1'b0;
                     state    <= S_IDLE;
                  end else begin
                     // Next issue overlaps the result_valid pulse.
                     pc      <= pc_next;
                     d_instr <= mem[pc_next];
                     run     <= 1'b1;
                     state   <= S_ISSUE;
                  end
               end
`ifdef BITTY_SEQ_TIMEOUT_EN
               else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_ERROR;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bitty_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_bitty_sequencer : directed bench with a behavioural core responder
// Rev 1.0
// ==========================================================================
module tb_bitty_sequencer;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [15:0]   load_data;
   logic [AW:0]   prog_len;
   logic          start;
   logic          core_done;
   logic [15:0]   core_d_out;
   logic          run;
   logic [15:0]   d_instr;
   logic [AW-1:0] pc;
   logic [15:0]   last_result;
   logic          result_valid;
   logic          busy;
   logic          finished;
   logic          error;

   always #5 clk = ~clk;

   bitty_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .prog_len(prog_len), .start(start),
      .core_done(core_done), .core_d_out(core_d_out), .run(run),
      .d_instr(d_instr), .pc(pc), .last_result(last_result),
      .result_valid(result_valid), .busy(busy), .finished(finished),
      .error(error)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Behavioural core: answers each run after core_delay cycles.
   logic        core_auto = 1'b0;
   int          core_delay = 4;
   logic [15:0] resp [0:31];
   int          resp_idx = 0;

   initial begin
      core_done  = 1'b0;
      core_d_out = '0;
      forever begin
         @(negedge clk);
         if (core_auto) core_done = 1'b0;
         if (core_auto && run && reset) begin
            repeat (core_delay) @(negedge clk);
            core_done  = 1'b1;
            core_d_out = resp[resp_idx % 32];
            resp_idx++;
         end
      end
   end

   // Monitor logs
   int          cyc = 0;
   logic [15:0] run_instr [$];
   int          run_pc [$];
   int          run_cyc [$];
   logic [15:0] rv_res [$];
   int          fin_cnt = 0;
   int          fin_rv = 0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (run) begin
            run_instr.push_back(d_instr);
            run_pc.push_back(int'(pc));
            run_cyc.push_back(cyc);
         end
         if (result_valid) rv_res.push_back(last_result);
         if (finished) begin
            fin_cnt++;
            if (result_valid) fin_rv++;
         end
      end
   end

   task automatic clear_logs();
      run_instr.delete(); run_pc.delete(); run_cyc.delete(); rv_res.delete();
      fin_cnt = 0; fin_rv = 0;
   endtask

   task automatic load_word(input int a, input logic [15:0] d);
      load_en = 1'b1; load_addr = AW'(a); load_data = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic pulse_start(input int n);
      start = 1'b1; prog_len = (AW+1)'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_fin(input int maxc);
      int n = 0;
      while (fin_cnt == 0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("fin_timeout", 32'(fin_cnt != 0), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int bad;
      reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      prog_len = '0; start = 1'b0;
      for (int i = 0; i < 32; i++) resp[i] = 16'h0100 + 16'(i);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_run", 32'(run), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_last_result", 32'(last_result), 0);
      chk("rst_d_instr", 32'(d_instr), 0);
      chk("rst_rv_fin_err", {29'd0, result_valid, finished, error}, 0);
      reset = 1'b1;
      @(negedge clk);

      // Zero-length program
      clear_logs();
      pulse_start(0);
      chk("zl_fin", 32'(finished), 1);
      chk("zl_busy", 32'(busy), 0);
      chk("zl_run", 32'(run), 0);
      @(negedge clk);
      chk("zl_fin_pulse", 32'(finished), 0);
      chk("zl_runs", 32'(run_instr.size()), 0);

      // Three-instruction program, done 4 cycles after each run
      load_word(0, 16'h1234); load_word(1, 16'h5678); load_word(2, 16'h9ABC);
      resp[0] = 16'h0011; resp[1] = 16'h0022; resp[2] = 16'h0033;
      resp_idx = 0; core_delay = 4; core_auto = 1'b1;
      clear_logs();
      pulse_start(3);
      chk("lat_run", 32'(run), 1);
      chk("lat_busy", 32'(busy), 1);
      wait_fin(60);
      chk("p3_runs", 32'(run_instr.size()), 3);
      chk("p3_instr0", 32'(run_instr[0]), 32'h1234);
      chk("p3_instr1", 32'(run_instr[1]), 32'h5678);
      chk("p3_instr2", 32'(run_instr[2]), 32'h9ABC);
      chk("p3_pc2", 32'(run_pc[2]), 2);
      chk("p3_period", 32'(run_cyc[1] - run_cyc[0]), 5);
      chk("p3_rvs", 32'(rv_res.size()), 3);
      chk("p3_res0", 32'(rv_res[0]), 32'h0011);
      chk("p3_res1", 32'(rv_res[1]), 32'h0022);
      chk("p3_res2", 32'(rv_res[2]), 32'h0033);
      chk("p3_fin_with_rv", 32'(fin_rv), 1);
      chk("p3_busy_end", 32'(busy), 0);

      // Back-to-back, full depth
      for (int i = 0; i < DEPTH; i++) load_word(i, 16'hA000 + 16'(i));
      for (int i = 0; i < 32; i++) resp[i] = 16'h0100 + 16'(i);
      resp_idx = 0; core_delay = 1;
      clear_logs();
      pulse_start(DEPTH);
      wait_fin(200);
      bad = 0;
      for (int i = 1; i < run_cyc.size(); i++) if (run_cyc[i] - run_cyc[i-1] != 2) bad++;
      chk("b2b_runs", 32'(run_instr.size()), 16);
      chk("b2b_bad_periods", 32'(bad), 0);
      chk("b2b_instr7", 32'(run_instr[7]), 32'hA007);
      chk("b2b_last_pc", 32'(run_pc[15]), 15);
      chk("b2b_pc_end", 32'(pc), 15);
      chk("b2b_rvs", 32'(rv_res.size()), 16);
      chk("b2b_res15", 32'(rv_res[15]), 32'h010F);
      chk("b2b_fin_cnt", 32'(fin_cnt), 1);

      // prog_len above DEPTH is clamped
      resp_idx = 0;
      clear_logs();
      pulse_start(31);
      wait_fin(200);
      chk("clamp_runs", 32'(run_instr.size()), 16);

      // Load and start while busy are ignored
      load_word(0, 16'h1234); load_word(1, 16'h5678); load_word(2, 16'h9ABC);
      resp[0] = 16'h0011; resp[1] = 16'h0022; resp[2] = 16'h0033;
      resp_idx = 0; core_delay = 4;
      clear_logs();
      pulse_start(3);
      @(negedge clk);
      load_en = 1'b1; load_addr = 4'd1; load_data = 16'hFFFF;
      start = 1'b1; prog_len = 5'd3;
      @(negedge clk);
      load_en = 1'b0; start = 1'b0;
      wait_fin(60);
      chk("prot_runs", 32'(run_instr.size()), 3);
      chk("prot_mem1", 32'(run_instr[1]), 32'h5678);
      chk("prot_pc1", 32'(run_pc[1]), 1);

      // Spurious core_done in IDLE and ISSUE
      core_auto = 1'b0;
      repeat (2) @(negedge clk);
      core_done = 1'b1; core_d_out = 16'hDEAD;
      @(negedge clk);
      core_done = 1'b0;
      chk("sp_idle_rv", 32'(result_valid), 0);
      chk("sp_idle_res", 32'(last_result), 32'h0033);
      pulse_start(1);
      core_done = 1'b1; core_d_out = 16'hBEEF;
      @(negedge clk);
      core_done = 1'b0;
      chk("sp_issue_rv", 32'(result_valid), 0);
      chk("sp_issue_busy", 32'(busy), 1);
      @(negedge clk);
      core_done = 1'b1; core_d_out = 16'h0BEE;
      @(negedge clk);
      core_done = 1'b0;
      chk("sp_real_rv_fin", {30'd0, result_valid, finished}, 32'h3);
      chk("sp_real_res", 32'(last_result), 32'h0BEE);

      // Reset during WAIT of the second instruction
      @(negedge clk);
      resp_idx = 0; core_delay = 4; core_auto = 1'b1;
      clear_logs();
      pulse_start(3);
      repeat (7) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("mr_busy", 32'(busy), 0);
      chk("mr_pc", 32'(pc), 0);
      chk("mr_last_result", 32'(last_result), 0);
      chk("mr_run_rv", {30'd0, run, result_valid}, 0);
      chk("mr_runs_before", 32'(run_instr.size()), 2);
      repeat (4) @(negedge clk);
      chk("mr_no_fin", 32'(fin_cnt), 0);
      resp_idx = 0;
      clear_logs();
      pulse_start(3);
      chk("mr_restart_instr", 32'(d_instr), 32'h1234);
      chk("mr_restart_pc", 32'(pc), 0);
      wait_fin(60);
      chk("mr_restart_rvs", 32'(rv_res.size()), 3);
      chk("mr_restart_res2", 32'(rv_res[2]), 32'h0033);

      // Core never answers
      core_auto = 1'b0;
      @(negedge clk);
      clear_logs();
`ifdef BITTY_SEQ_TIMEOUT_EN
      pulse_start(1);
      repeat (8) @(negedge clk);
      chk("wd_before", 32'(error), 0);
      @(negedge clk);
      chk("wd_error", 32'(error), 1);
      chk("wd_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);
      chk("wd_sticky", 32'(error), 1);
      chk("wd_no_fin", 32'(fin_cnt), 0);
      pulse_start(1);
      chk("wd_clear", 32'(error), 0);
      chk("wd_reissue", {15'd0, run, d_instr}, {15'd0, 1'b1, 16'h1234});
`else
      pulse_start(1);
      repeat (20) @(negedge clk);
      chk("nowd_error", 32'(error), 0);
      chk("nowd_busy", 32'(busy), 1);
`endif
      @(negedge clk);
      core_done = 1'b1; core_d_out = 16'h0777;
      @(negedge clk);
      core_done = 1'b0;
      chk("hang_fin", 32'(finished), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bitty_sequencer.md
Name: bitty_sequencer

Overview:
- Instruction-issue front end for the bitty core: drives the core's run/d_instr inputs and consumes its d_out/done outputs.
- Holds a small program memory, loaded through a write port. Issues the stored instructions one at a time and waits for done after each one.
- Captures every result and reports program completion.
- Sits between the testbench/host and the bitty core, replacing hand-driven instruction stimulus.

Parameters:
DEPTH, 16, number of 16-bit instruction words in program memory (power of 2, 2..256)
AW, $clog2(DEPTH), address/PC width
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
load_en  input  1  write program word this cycle
load_addr  input  AW  program memory write address
load_data  input  16  instruction word to write
prog_len  input  AW+1  number of instructions to run (0..DEPTH); sampled on start
start  input  1  begin execution from address 0; one-cycle pulse
core_done  input  1  core's done output
core_d_out  input  16  core's d_out output
run  output  1  to core run; one-cycle pulse per instruction
d_instr  output  16  to core d_instr
pc  output  AW  address of the instruction currently issued
last_result  output  16  core_d_out captured at the most recent core_done
result_valid  output  1  one-cycle pulse; last_result updated
busy  output  1  high from start until program end
finished  output  1  one-cycle pulse when the last result is captured, or when prog_len==0
error  output  1  watchdog tripped (optional feature only; else constant 0)

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE.
  - Cleared: pc, last_result, run, result_valid, busy, finished, error, d_instr, latched length, watchdog count.
  - Program memory contents are not cleared.
- Program memory write: synchronous write when load_en=1 in IDLE. Ignored while busy=1.
- States: IDLE, ISSUE, WAIT, (ERROR with the optional feature).
- IDLE:
  - start=1 with prog_len==0: finished pulses next cycle; busy stays 0.
  - start=1 with prog_len>0: latch prog_len, pc<=0, go to ISSUE next cycle (busy=1).
  - prog_len>DEPTH is clamped to DEPTH.
- ISSUE (exactly 1 cycle):
  - run=1; d_instr=mem[pc].
  - Next state WAIT.
  - core_done is ignored in this cycle.
- WAIT:
  - run=0; d_instr is held at mem[pc] (stable until done).
  - On core_done=1: last_result<=core_d_out.
    - result_valid pulses in the following cycle.
    - If pc==len-1: finished pulses with result_valid, busy drops, go to IDLE.
    - Else: pc<=pc+1 and go to ISSUE.
  - The next run is therefore concurrent with result_valid; minimum per-instruction period is 2 cycles.
- Latency: start at edge N -> run high in cycle N+1.
- pc never wraps: the maximum value is DEPTH-1.
- start while busy: ignored.
- load_en while busy: ignored.
- core_done in IDLE: ignored.
- Simultaneous start and load_en in IDLE: both take effect. The write lands before the first fetch only if it targets an address >0; a write to address 0 in the same cycle is not guaranteed to be issued.
- Reset mid-program: all outputs return to reset values at the next edge. No finished pulse.

Optional Feature:
- Macro BITTY_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counts WAIT cycles; it is cleared on each entry to WAIT.
  - If TIMEOUT_CYCLES cycles elapse without core_done, go to ERROR: error=1, busy=0, run=0, no finished pulse.
  - ERROR is left only by reset, or by start, which clears error and restarts as from IDLE.
  - Loads are accepted in ERROR.
- Undefined: no counter logic; WAIT waits indefinitely; error tied to 0.

Test Plan:
- Reset + idle: drive reset=0 for 2 cycles -> all outputs 0. start with prog_len=0 -> finished pulse 1 cycle later, run never asserted, busy stays 0.
- Load 3 words (0x1234, 0x5678, 0x9ABC) at addr 0..2, prog_len=3, start; model core asserts done 4 cycles after each run with d_out=0x0011,0x0022,0x0033:
  - run pulses 3 times with d_instr 0x1234, 0x5678, 0x9ABC.
  - result_valid pulses 3 times with last_result 0x0011, 0x0022, 0x0033.
  - finished coincides with the third result_valid.
- Back-to-back: core asserts done in the first WAIT cycle, prog_len=DEPTH -> run period exactly 2 cycles; pc reaches DEPTH-1, no wrap; finished after DEPTH results.
- Protection:
  - load_en to addr 1 with 0xFFFF while busy -> memory unchanged.
  - start while busy -> pc not reset.
  - Spurious core_done during ISSUE or IDLE -> no result_valid.
- Reset mid-program: reset=0 during WAIT of instruction 2 -> next cycle busy=0, pc=0, last_result=0, no finished. A fresh start reruns from address 0.
- With BITTY_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, core never returns done -> error=1 after 8 WAIT cycles, busy=0. A following start clears error and reissues address 0.
